// File: rtl/hack_bus_pkg.sv
// Shared types and constants for the Hack CPU data-port bus router.
// Holds the region codes the address decoder produces, the address
// boundaries between regions, the router state enum and a small helper
// that expands a region code into its one-hot target strobe.
package hack_bus_pkg;

  // First SCREEN address; everything below it is RAM.
  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  // The single keyboard register; everything above it is PERIPH.
  localparam logic [14:0] KBD_ADDR    = 15'h6000;

  typedef enum logic [1:0] {
    REG_RAM    = 2'd0,
    REG_SCREEN = 2'd1,
    REG_KBD    = 2'd2,
    REG_PERIPH = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Bit i of the result selects target i (RAM, SCREEN, KBD, PERIPH).
  function automatic logic [3:0] region_onehot(region_e region);
    logic [3:0] onehot;
    onehot = 4'b0001 << region;
    return onehot;
  endfunction

endpackage

// File: rtl/mem_bus_router_if.sv
// Bus bundle between the Hack CPU data port, the router and the four
// memory-mapped targets.
//   req_*  : CPU request (valid/ready handshake, write flag, address, data)
//   rsp_*  : one-cycle response pulse with read data and error flag
//   dev_*  : one-hot target strobe, latched request fields, per-target
//            acknowledge and flattened per-target read data
// Modports:
//   slave  : the router's view (takes requests, drives targets)
//   master : the CPU/target side's view (the opposite directions)
interface mem_bus_router_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  logic [3:0]            dev_sel;
  logic                  dev_we;
  logic [ADDR_W-1:0]     dev_addr;
  logic [DATA_W-1:0]     dev_wdata;
  logic [3:0]            dev_ack;
  logic [4*DATA_W-1:0]   dev_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, dev_ack, dev_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           dev_sel, dev_we, dev_addr, dev_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, dev_ack, dev_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           dev_sel, dev_we, dev_addr, dev_wdata
  );

endinterface

// File: rtl/mem_region_decode.sv
// Combinational address decoder for the Hack data-port memory map.
// Ports:
//   addr   : request address
//   region : 2-bit target region
//            0x0000-0x3FFF RAM, 0x4000-0x5FFF SCREEN,
//            0x6000 KBD, 0x6001-0x7FFF PERIPH
module mem_region_decode
  import hack_bus_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic [ADDR_W-1:0] addr,
  output region_e           region
);

  always_comb begin
    region = REG_PERIPH;
    if (addr < ADDR_W'(SCREEN_BASE)) begin
      region = REG_RAM;
    end else if (addr < ADDR_W'(KBD_ADDR)) begin
      region = REG_SCREEN;
    end else if (addr == ADDR_W'(KBD_ADDR)) begin
      region = REG_KBD;
    end
  end

endmodule

// File: rtl/mem_bus_router.sv
// Single-outstanding bus router between the Hack CPU data port and the
// RAM, SCREEN, KBD and PERIPH targets. A request is latched in IDLE, the
// decoded target is strobed for one cycle (ISSUE), the router then waits
// for that target's acknowledge or a timeout (WAIT) and returns one
// response pulse (RESP).
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : mem_bus_router_if.slave (CPU request/response + target side)
//   err_count : saturating count of timed-out requests; present only when
//               MEM_BUS_ROUTER_STATS_EN is defined
// All outputs are registered, so every output reads 0 while rst_n is low.
module mem_bus_router
  import hack_bus_pkg::*;
#(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_bus_router_if.slave bus
`ifdef MEM_BUS_ROUTER_STATS_EN
  ,
  output logic [7:0]      err_count
`endif
);

  state_e              state_q, state_d;
  region_e             region_q, region_d;
  region_e             dec_region;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [3:0]          sel_q, sel_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                accept;
  logic                ack_hit;
  logic [DATA_W-1:0]   ack_data;
  logic [7:0]          cnt_inc;
  logic                timeout_hit;

  mem_region_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .addr   (bus.req_addr),
    .region (dec_region)
  );

  // ready_q gates acceptance so a request held during reset release is
  // not taken before the CPU has seen ready.
  assign accept      = (state_q == IDLE) && ready_q && bus.req_valid;
  assign cnt_inc     = cnt_q + 8'd1;
  assign timeout_hit = (cnt_inc == 8'(TIMEOUT_CYCLES));

  // Only the latched target's acknowledge and data slice matter.
  always_comb begin
    ack_hit  = 1'b0;
    ack_data = '0;
    case (region_q)
      REG_RAM: begin
        ack_hit  = bus.dev_ack[0];
        ack_data = bus.dev_rdata[0*DATA_W +: DATA_W];
      end
      REG_SCREEN: begin
        ack_hit  = bus.dev_ack[1];
        ack_data = bus.dev_rdata[1*DATA_W +: DATA_W];
      end
      REG_KBD: begin
        ack_hit  = bus.dev_ack[2];
        ack_data = bus.dev_rdata[2*DATA_W +: DATA_W];
      end
      default: begin
        ack_hit  = bus.dev_ack[3];
        ack_data = bus.dev_rdata[3*DATA_W +: DATA_W];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An acknowledge arriving in the expiry cycle still ends WAIT normally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (ack_hit || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values. Acknowledge takes priority over the
  // timeout; write responses always return zero data.
  always_comb begin
    region_d    = region_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          region_d = dec_region;
          we_d     = bus.req_we;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
        end
      end
      ISSUE: begin
        cnt_d = '0;
      end
      WAIT: begin
        if (ack_hit) begin
          rsp_rdata_d = we_q ? '0 : ack_data;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
    ready_d     = (state_d == IDLE);
    sel_d       = (state_d == ISSUE) ? region_onehot(region_d) : 4'b0000;
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_q    <= REG_RAM;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      sel_q       <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      region_q    <= region_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.dev_sel   = sel_q;
  assign bus.dev_we    = we_q;
  assign bus.dev_addr  = addr_q;
  assign bus.dev_wdata = wdata_q;

`ifdef MEM_BUS_ROUTER_STATS_EN
  logic [7:0] err_count_q, err_count_d;

  // Counted on entry to an error RESP; saturates at 255.
  always_comb begin
    err_count_d = err_count_q;
    if ((state_q == WAIT) && (state_d == RESP) && rsp_err_d &&
        (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_mem_bus_router.sv
// Directed self-checking bench for mem_bus_router. Inputs change 1 time
// unit after each rising edge and outputs are sampled there as well.
module tb_mem_bus_router;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

`ifdef MEM_BUS_ROUTER_STATS_EN
  logic [7:0] err_count;
`endif

  mem_bus_router_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  mem_bus_router #(
    .ADDR_W         (15),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef MEM_BUS_ROUTER_STATS_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read data for every slot; non-selected slots carry decoy values.
  function automatic logic [63:0] buildData(input logic [3:0] sel,
                                            input logic [15:0] data);
    logic [63:0] v;
    for (int i = 0; i < 4; i++) begin
      v[i*16 +: 16] = sel[i] ? data : (16'hD000 | 16'(i));
    end
    return v;
  endfunction

  // Waits (bounded) for ready, presents one request and lets it be taken.
  task automatic applyStimulus(input string tag, input logic we,
                               input logic [14:0] addr, input logic [15:0] wdata);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  // One full transaction: ackWait no-ack WAIT cycles, then ackBits held
  // until the response; expLatency counts edges from that point.
  task automatic runTxn(input string tag, input logic we, input logic [14:0] addr,
                        input logic [15:0] wdata, input int ackWait,
                        input logic [3:0] ackBits, input logic [15:0] devData,
                        input logic [3:0] expSel, input logic [15:0] expRdata,
                        input logic expErr, input int expLatency);
    int n;
    applyStimulus(tag, we, addr, wdata);
    checkOutput({tag, "_sel"},    64'(bus.dev_sel),   64'(expSel));
    checkOutput({tag, "_busy"},   64'(bus.req_ready), 64'd0);
    checkOutput({tag, "_we"},     64'(bus.dev_we),    64'(we));
    checkOutput({tag, "_addr"},   64'(bus.dev_addr),  64'(addr));
    checkOutput({tag, "_wdata"},  64'(bus.dev_wdata), 64'(wdata));
    bus.dev_rdata = buildData(expSel, devData);
    tick();
    checkOutput({tag, "_selOff"}, 64'(bus.dev_sel),   64'd0);
    repeat (ackWait) tick();
    bus.dev_ack = ackBits;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.rsp_valid && n < 40);
    checkOutput({tag, "_rspValid"}, 64'(bus.rsp_valid), 64'd1);
    checkOutput({tag, "_latency"},  64'(n),             64'(expLatency));
    checkOutput({tag, "_rdata"},    64'(bus.rsp_rdata), 64'(expRdata));
    checkOutput({tag, "_err"},      64'(bus.rsp_err),   64'(expErr));
    checkOutput({tag, "_addrHold"}, 64'(bus.dev_addr),  64'(addr));
    bus.dev_ack = 4'b0000;
    tick();
    checkOutput({tag, "_pulse"},     64'(bus.rsp_valid), 64'd0);
    checkOutput({tag, "_rdataHold"}, 64'(bus.rsp_rdata), 64'(expRdata));
    checkOutput({tag, "_idle"},      64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    logic sawRsp;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.dev_ack   = 4'b0000;
    bus.dev_rdata = '0;

    repeat (2) tick();
    checkOutput("rst_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("rst_sel",   64'(bus.dev_sel),   64'd0);
    checkOutput("rst_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready0", 64'(bus.req_ready), 64'd0);
    tick();
    checkOutput("rel_ready1", 64'(bus.req_ready), 64'd1);

    runTxn("ramRd",  1'b0, 15'h0010, 16'h0000, 0, 4'b0001, 16'h1234, 4'b0001, 16'h1234, 1'b0, 1);
    runTxn("scrWr",  1'b1, 15'h4005, 16'hBEEF, 2, 4'b0010, 16'h5555, 4'b0010, 16'h0000, 1'b0, 1);

    runTxn("b3FFF",  1'b0, 15'h3FFF, 16'h0000, 0, 4'b0001, 16'h1111, 4'b0001, 16'h1111, 1'b0, 1);
    runTxn("b4000",  1'b0, 15'h4000, 16'h0000, 0, 4'b0010, 16'h2222, 4'b0010, 16'h2222, 1'b0, 1);
    runTxn("b5FFF",  1'b0, 15'h5FFF, 16'h0000, 0, 4'b0010, 16'h3333, 4'b0010, 16'h3333, 1'b0, 1);
    runTxn("b6000",  1'b0, 15'h6000, 16'h0000, 0, 4'b0100, 16'h4444, 4'b0100, 16'h4444, 1'b0, 1);
    runTxn("b6001",  1'b0, 15'h6001, 16'h0000, 0, 4'b1000, 16'h5A5A, 4'b1000, 16'h5A5A, 1'b0, 1);

    runTxn("tmo",    1'b0, 15'h7000, 16'h0000, 0, 4'b0000, 16'hAAAA, 4'b1000, 16'h0000, 1'b1, 15);
`ifdef MEM_BUS_ROUTER_STATS_EN
    checkOutput("tmo_errCount", 64'(err_count), 64'd1);
`endif
    runTxn("expAck", 1'b0, 15'h7000, 16'h0000, 14, 4'b1000, 16'h7777, 4'b1000, 16'h7777, 1'b0, 1);
`ifdef MEM_BUS_ROUTER_STATS_EN
    checkOutput("expAck_errCount", 64'(err_count), 64'd1);
`endif

    // KBD ack held high must not answer a RAM request.
    bus.dev_ack   = 4'b0100;
    bus.dev_rdata = buildData(4'b0001, 16'h0BAD);
    applyStimulus("wrongAck", 1'b0, 15'h0020, 16'h0000);
    checkOutput("wrongAck_sel", 64'(bus.dev_sel), 64'd1);
    sawRsp = 1'b0;
    repeat (7) begin
      tick();
      if (bus.rsp_valid) sawRsp = 1'b1;
    end
    checkOutput("wrongAck_noRsp", 64'(sawRsp), 64'd0);
    bus.dev_ack = 4'b0101;
    tick();
    checkOutput("wrongAck_rsp",   64'(bus.rsp_valid), 64'd1);
    checkOutput("wrongAck_rdata", 64'(bus.rsp_rdata), 64'h0BAD);
    checkOutput("wrongAck_err",   64'(bus.rsp_err),   64'd0);
    bus.dev_ack = 4'b0000;
    tick();

    // Reset pulse during WAIT.
    applyStimulus("midRst", 1'b0, 15'h0040, 16'h0000);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midRst_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("midRst_sel",   64'(bus.dev_sel),   64'd0);
    checkOutput("midRst_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("midRst_addr",  64'(bus.dev_addr),  64'd0);
    checkOutput("midRst_rdata", 64'(bus.rsp_rdata), 64'd0);
`ifdef MEM_BUS_ROUTER_STATS_EN
    checkOutput("midRst_errCount", 64'(err_count), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midRst_noRsp", 64'(bus.rsp_valid), 64'd0);
    tick();
    checkOutput("midRst_noRsp2", 64'(bus.rsp_valid), 64'd0);
    runTxn("postRst", 1'b0, 15'h6000, 16'h0000, 0, 4'b0100, 16'h00C3, 4'b0100, 16'h00C3, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_router.md
Name: mem_bus_router

Overview:
- Single-outstanding bus router between the Hack CPU data port and four memory-mapped targets: RAM, SCREEN, KBD, PERIPH.
- Decodes the 15-bit address into a 2-bit region and issues a one-cycle one-hot select strobe to that target.
- Waits for the target's acknowledge, then returns registered read data and an error flag to the CPU.
- Sits directly upstream of the per-region write-enable demultiplexing and the RAM/screen banks.

Parameters:
- ADDR_W, 15, CPU address width.
- DATA_W, 16, data width.
- TIMEOUT_CYCLES, 15, WAIT cycles without an acknowledge before an error response. Legal range 1..255.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  reset. Asynchronous assert, active-low.
- REQ_VALID  in  1  CPU request present.
- REQ_READY  out  1  router can accept a request this cycle.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  ADDR_W  request address.
- REQ_WDATA  in  DATA_W  write data.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_RDATA  out  DATA_W  read data. 0 for writes and for errors.
- RSP_ERR  out  1  timeout on the request being answered.
- DEV_SEL  out  4  one-hot target strobe: bit0 RAM, bit1 SCREEN, bit2 KBD, bit3 PERIPH.
- DEV_WE  out  1  latched REQ_WE.
- DEV_ADDR  out  ADDR_W  latched address.
- DEV_WDATA  out  DATA_W  latched write data.
- DEV_ACK  in  4  per-target acknowledge.
- DEV_RDATA  in  4*DATA_W  target read data, flattened. Target i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Clock and reset: one clock (CLK); reset RST_N is asynchronous and active-low. While RST_N = 0:
  - state = IDLE, REQ_READY = 0;
  - all other outputs and latched registers = 0, timeout counter = 0.
  - REQ_READY rises in the first cycle after reset deasserts.
- Region decode:
  - 0x0000–0x3FFF → RAM (0)
  - 0x4000–0x5FFF → SCREEN (1)
  - 0x6000 → KBD (2)
  - 0x6001–0x7FFF → PERIPH (3)
- IDLE:
  - REQ_READY = 1.
  - On REQ_VALID = 1, latch WE/ADDR/WDATA and the decoded region, then go to ISSUE.
- ISSUE (exactly one cycle):
  - DEV_SEL = one-hot of the region; REQ_READY = 0; counter cleared; go to WAIT.
- WAIT:
  - DEV_SEL = 0.
  - If DEV_ACK[region] = 1: capture the selected DEV_RDATA slice (forced to 0 on writes), RSP_ERR = 0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES: RDATA = 0, ERR = 1, go to RESP.
  - An acknowledge in the same cycle the counter expires wins; no error is reported.
  - DEV_ACK bits of non-selected targets are ignored.
  - DEV_ACK is not sampled during ISSUE.
- RESP:
  - RSP_VALID = 1 for exactly one cycle, then go to IDLE.
  - RSP_RDATA and RSP_ERR hold their values until the next RESP.
- Latency: request accepted at edge N → strobe during cycle N+1 → earliest acknowledge sampled at N+2 → RSP_VALID in cycle N+3.
- Throughput: one request per 4 cycles at best.
- DEV_WE, DEV_ADDR and DEV_WDATA stay stable from ISSUE through RESP.
- Reset asserted mid-transaction: immediate return to the IDLE reset values. No response is emitted and the target strobe is dropped.

Optional Feature:
- Macro: MEM_BUS_ROUTER_STATS_EN.
- When defined:
  - extra output ERR_COUNT[7:0], saturating at 255;
  - increments on each RESP with RSP_ERR = 1;
  - cleared by RST_N only.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package hack_bus_pkg holds:
  - region codes REG_RAM/REG_SCREEN/REG_KBD/REG_PERIPH;
  - address boundary constants SCREEN_BASE = 0x4000, KBD_ADDR = 0x6000;
  - state enum IDLE/ISSUE/WAIT/RESP.
- One sub-module, mem_region_decode: combinational, REQ_ADDR → 2-bit region. The router expands the region to one-hot DEV_SEL.

Test Plan:
- Read RAM: addr 0x0010, RAM acks one cycle after the strobe with 0x1234 → DEV_SEL = 0001 for one cycle; RSP_VALID at N+3; RDATA 0x1234; ERR 0.
- Write SCREEN: addr 0x4005, wdata 0xBEEF, ack after 3 cycles → DEV_SEL = 0010; DEV_WE = 1; DEV_WDATA 0xBEEF; RDATA 0; ERR 0.
- Boundaries: addr 0x3FFF, 0x4000, 0x5FFF, 0x6000, 0x6001 → DEV_SEL 0001, 0010, 0010, 0100, 1000.
- Timeout: read 0x7000 with PERIPH never acking, TIMEOUT_CYCLES = 15 → RSP_VALID with ERR 1, RDATA 0. With STATS_EN, ERR_COUNT = 1. Acknowledge in the expiry cycle → ERR 0.
- Wrong-target ack: a RAM request while DEV_ACK = 0100 is held high → no response until DEV_ACK[0] rises.
- Reset mid-WAIT: RST_N low for 1 cycle during WAIT → all outputs 0 immediately; no RSP_VALID; a new request is accepted normally afterwards.
